mul_share_arbiter: RTL and testbench



---
 rtl/mul_arb_pkg.sv | 14 +
 rtl/mul_rr_pick.sv | 37 +++
 rtl/vecTrans2_mul_32s_32s_32_2_1.sv | 23 ++
 rtl/mul_share_arbiter.sv | 120 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// The tag is sized for the largest supported requester count (8).
package mul_arb_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_REQ   = 8;
    localparam int TAG_W     = $clog2(MAX_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input tag_t tag);
        return MAX_REQ'(1) << tag;
    endfunction
endpackage

// File: rtl/mul_rr_pick.sv
// Rotate-priority picker: first asserted request at or above ptr wins,
// otherwise the lowest asserted request (wrap-around).
module mul_rr_pick
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  tag_t             ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output tag_t             grant_idx,
    output logic             any
);
    logic w_found_hi;
    tag_t w_idx_hi;
    tag_t w_idx_lo;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        w_found_hi = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_idx_lo = tag_t'(j);
                if (j >= int'(ptr)) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = tag_t'(j);
                end
            end
        end
    end

    assign any          = |req;
    assign grant_idx    = w_found_hi ? w_idx_hi : w_idx_lo;
    assign grant_onehot = any ? N_REQ'(onehot(grant_idx)) : '0;
endmodule

// File: rtl/vecTrans2_mul_32s_32s_32_2_1.sv
// Signed multiplier with one clock-enabled output register; the product is
// truncated to dout_WIDTH bits and the register is intentionally not reset.
module vecTrans2_mul_32s_32s_32_2_1 #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    logic [dout_WIDTH-1:0] buff0;

    always_ff @(posedge clk) begin
        if (ce) begin
            buff0 <= dout_WIDTH'($signed(din0) * $signed(din1));
        end
    end

    assign dout = buff0;
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 2-stage signed multiplier among N_REQ requesters;
// the whole pipeline freezes while the head result's owner is not ready.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        res_valid,
    input  logic [N_REQ-1:0]        res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic                    busy
);
    logic              r_s1_valid;
    logic              r_s2_valid;
    tag_t              r_s1_tag;
    tag_t              r_s2_tag;
    tag_t              r_ptr;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;

    logic [N_REQ-1:0]  w_grant_oh;
    logic [N_REQ-1:0]  w_s2_oh;
    tag_t              w_grant_idx;
    tag_t              w_ptr_next;
    logic              w_any;
    logic              w_stall;
    logic              w_ce;
    logic              w_accept;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [DATA_W-1:0] w_mul_dout;
    logic [DATA_W-1:0] w_a_arr [N_REQ];
    logic [DATA_W-1:0] w_b_arr [N_REQ];

    mul_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req          (req_valid),
        .ptr          (r_ptr),
        .grant_onehot (w_grant_oh),
        .grant_idx    (w_grant_idx),
        .any          (w_any)
    );

    // Only the owner of the head result can release a stall.
    assign w_s2_oh    = N_REQ'(onehot(r_s2_tag));
    assign w_stall    = r_s2_valid & ~|(w_s2_oh & res_ready);
    assign w_ce       = ~w_stall;
    assign w_accept   = w_any & w_ce & ~reset;
    assign req_ready  = w_accept ? w_grant_oh : '0;
    assign w_ptr_next = (w_grant_idx == tag_t'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
            assign w_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_grant_oh[j]) begin
                w_sel_a = w_a_arr[j];
                w_sel_b = w_b_arr[j];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_ce) begin
                r_s2_valid <= r_s1_valid;
                r_s2_tag   <= r_s1_tag;
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_tag <= w_grant_idx;
                end
            end
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Operand registers carry no control meaning, so they are left unreset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a <= w_sel_a;
            r_s1_b <= w_sel_b;
        end
    end

    vecTrans2_mul_32s_32s_32_2_1 #(
        .din0_WIDTH (DATA_W),
        .din1_WIDTH (DATA_W),
        .dout_WIDTH (DATA_W)
    ) u_mul (
        .clk  (clk),
        .ce   (w_ce),
        .din0 (r_s1_a),
        .din1 (r_s1_b),
        .dout (w_mul_dout)
    );

    assign res_valid = r_s2_valid ? w_s2_oh : '0;
    assign res_data  = r_s2_valid ? w_mul_dout : '0;
    assign busy      = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench: vector table, scoreboard queue of expected results,
// and hand-written sequences for stall, non-owner ready and mid-flight reset.
module tb_mul_share_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   res_valid;
    logic [3:0]   res_ready;
    logic [31:0]  res_data;
    logic         busy;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[8];
    int   checks   = 0;
    int   failures = 0;
    int   n_res    = 0;

    logic        prev_stall = 1'b0;
    logic [3:0]  prev_rv    = 4'b0;
    logic [31:0] prev_data  = 32'd0;

    mul_share_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            set_op(i, $urandom, $urandom);
        end
    endtask

    // One clock: check grant (and optionally res_valid) at negedge, push the
    // expected result of the grant, then step to just after the next posedge.
    task automatic cyc(input logic [3:0] exp_rdy, input bit use_val, input logic [31:0] val,
                       input bit chk_rv, input logic [3:0] exp_rv, input string name);
        exp_t e;
        int   g;
        @(negedge clk);
        chk({name, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (chk_rv) chk({name, ".res_valid"}, 32'(res_valid), 32'(exp_rv));
        if (exp_rdy != 4'b0) begin
            g      = oh2idx(exp_rdy);
            e.rv   = exp_rdy;
            e.data = use_val ? val : model(req_a[g*32 +: 32], req_b[g*32 +: 32]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk({name, ".drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold.res_valid", 32'(res_valid), 32'(prev_rv));
                chk("hold.res_data", res_data, prev_data);
            end
            if (res_valid != 4'b0) begin
                chk("res_valid.onehot", 32'($countones(res_valid)), 32'd1);
                if ((res_valid & res_ready) != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_result: got res_valid=%b res_data=%h, expected none",
                                 res_valid, res_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res.tag", 32'(res_valid), 32'(e.rv));
                        chk("res.data", res_data, e.data);
                        n_res++;
                        $display("result %0d: res_valid=%b res_data=%h", n_res, res_valid, res_data);
                    end
                    prev_stall = 1'b0;
                end else begin
                    chk("stall.req_ready", 32'(req_ready), 32'd0);
                    prev_stall = 1'b1;
                end
            end else begin
                chk("idle.res_data", res_data, 32'd0);
                prev_stall = 1'b0;
            end
            prev_rv   = res_valid;
            prev_data = res_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1] = '{1, 32'h7FFFFFFF,  32'd2,        32'hFFFFFFFE};
        tbl[2] = '{2, 32'h80000000,  32'hFFFFFFFF, 32'h80000000};
        tbl[3] = '{3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001};
        tbl[4] = '{0, 32'h00010000,  32'h00010000, 32'h00000000};
        tbl[5] = '{1, 32'h12345678,  32'd0,        32'h00000000};
        tbl[6] = '{2, 32'hFFFFFF9C,  32'd25,       32'hFFFFF63C};
        tbl[7] = '{3, 32'd12345,     32'd6789,     32'h04FED79D};

        reset     = 1'b1;
        req_valid = 4'b1111;
        res_ready = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.res_data", res_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        req_valid = 4'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single requester, no stall: 7 * -3 from req1.
        set_op(1, 32'd7, 32'hFFFFFFFD);
        req_valid = 4'b0010;
        cyc(4'b0010, 1'b1, 32'hFFFFFFEB, 1'b1, 4'b0000, "single.c0");
        req_valid = 4'b0;
        @(negedge clk);
        chk("single.c1.busy", 32'(busy), 32'd1);
        chk("single.c1.res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single.c2.res_valid", 32'(res_valid), 32'b0010);
        chk("single.c2.res_data", res_data, 32'hFFFFFFEB);
        chk("single.c2.busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single.c3.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Vector table, one accept per cycle back to back.
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'(1 << tbl[i].req);
            set_op(tbl[i].req, tbl[i].a, tbl[i].b);
            cyc(4'(1 << tbl[i].req), 1'b1, tbl[i].exp, 1'b0, 4'b0, "tbl");
        end
        req_valid = 4'b0;
        drain("tbl");

        // All requesters valid from ptr=0: grants rotate 0,1,2,3,...
        do_reset();
        rand_ops();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc(4'(1 << (i % 4)), 1'b0, 32'd0, 1'b1,
                (i >= 2) ? 4'(1 << ((i - 2) % 4)) : 4'b0, "rr");
            set_op(i % 4, $urandom, $urandom);
        end
        req_valid = 4'b0;
        drain("rr");

        // Backpressure on req2's result while req0/req3 are valid.
        do_reset();
        rand_ops();
        req_valid = 4'b0100;
        cyc(4'b0100, 1'b0, 32'd0, 1'b1, 4'b0000, "bp0");
        req_valid = 4'b1001;
        res_ready = 4'b1011;
        cyc(4'b1000, 1'b0, 32'd0, 1'b1, 4'b0000, "bp1");
        set_op(3, $urandom, $urandom);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0100, "bp_stall");
        end
        res_ready = 4'b1111;
        cyc(4'b0001, 1'b0, 32'd0, 1'b1, 4'b0100, "bp_rel");
        req_valid = 4'b1000;
        cyc(4'b1000, 1'b0, 32'd0, 1'b1, 4'b1000, "bp_next");
        req_valid = 4'b0;
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0001, "bp_t0");
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b1000, "bp_t3");
        drain("bp");

        // Stall on tag 1: every other requester ready does not release it.
        set_op(1, $urandom, $urandom);
        req_valid = 4'b0010;
        cyc(4'b0010, 1'b0, 32'd0, 1'b1, 4'b0000, "no0");
        req_valid = 4'b0;
        res_ready = 4'b1101;
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0000, "no1");
        req_valid = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0010, "no_stall");
        end
        res_ready = 4'b1111;
        cyc(4'b0001, 1'b0, 32'd0, 1'b1, 4'b0010, "no_rel");
        req_valid = 4'b0;
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0000, "no_gap");
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0001, "no_t0");
        drain("no");

        // Reset with S1 and S2 both valid.
        set_op(2, $urandom, $urandom);
        set_op(0, $urandom, $urandom);
        req_valid = 4'b0100;
        cyc(4'b0100, 1'b0, 32'd0, 1'b1, 4'b0000, "rm0");
        req_valid = 4'b0001;
        cyc(4'b0001, 1'b0, 32'd0, 1'b1, 4'b0000, "rm1");
        req_valid = 4'b1010;
        set_op(1, $urandom, $urandom);
        reset = 1'b1;
        #1;
        chk("rm.req_ready", 32'(req_ready), 32'd0);
        chk("rm.res_valid", 32'(res_valid), 32'd0);
        chk("rm.res_data", res_data, 32'd0);
        chk("rm.busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(4'b0010, 1'b0, 32'd0, 1'b1, 4'b0000, "rm_first");
        req_valid = 4'b0;
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0000, "rm_s1");
        cyc(4'b0000, 1'b0, 32'd0, 1'b1, 4'b0010, "rm_res");
        drain("rm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
